// File: rtl/core_pll_reset_seq.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the downstream reset; retries failed attempts and latches FAULT.
module core_pll_reset_seq #(
  parameter int PLL_RST_CYCLES      = 10,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_A = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ?
                         LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_C = (MAX_A > PLL_RST_CYCLES) ? MAX_A : PLL_RST_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t       RST_LAST  = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t       STAB_LAST = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t       TO_LAST   = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
  localparam cnt_t       CNT_ONE   = cnt_t'(1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t     state_r, state_nx;
  cnt_t       cnt_r, cnt_nx;
  logic [3:0] retry_nx;
  logic [7:0] loss_nx;
  logic [1:0] sync_r;
  logic       lock_s;

  assign lock_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], pll_locked};
    end
  end

  // Next-state, shared counter and status-counter logic.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    retry_nx = retry_count;
    loss_nx  = lock_loss_cnt;
    case (state_r)
      RESET_PLL: begin
        if (cnt_r == RST_LAST) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = STABILIZE;
          cnt_nx   = '0;
        end else if (cnt_r == TO_LAST) begin
          cnt_nx = '0;
          if (retry_count == RETRY_MAX) begin
            state_nx = FAULT;
          end else begin
            state_nx = RESET_PLL;
            retry_nx = retry_count + 4'd1;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      STABILIZE: begin
        if (!lock_s) begin
          // Lock dropped: the timeout window starts over.
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt_r == STAB_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
          retry_nx = 4'd0;
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nx = RESET_PLL;
          cnt_nx   = '0;
          retry_nx = 4'd0;
          if (lock_loss_cnt != 8'hFF) begin
            loss_nx = lock_loss_cnt + 8'd1;
          end else begin
            loss_nx = lock_loss_cnt;
          end
        end else if (relock_req) begin
          state_nx = RESET_PLL;
          cnt_nx   = '0;
          retry_nx = 4'd0;
        end else begin
          state_nx = RUN;
        end
      end
      FAULT: begin
        if (relock_req) begin
          state_nx = RESET_PLL;
          cnt_nx   = '0;
          retry_nx = 4'd0;
        end else begin
          state_nx = FAULT;
        end
      end
      default: begin
        state_nx = RESET_PLL;
        cnt_nx   = '0;
      end
    endcase
  end

  // State register with Moore outputs decoded from the next state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= RESET_PLL;
      cnt_r         <= '0;
      retry_count   <= 4'd0;
      lock_loss_cnt <= 8'd0;
      pll_rst       <= 1'b1;
      sys_rst_n     <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state_r       <= state_nx;
      cnt_r         <= cnt_nx;
      retry_count   <= retry_nx;
      lock_loss_cnt <= loss_nx;
      pll_rst       <= (state_nx == RESET_PLL) || (state_nx == FAULT);
      sys_rst_n     <= (state_nx == RUN);
      ready         <= (state_nx == RUN);
      fault         <= (state_nx == FAULT);
    end
  end

endmodule

// File: tb/tb_core_pll_reset_seq.sv
// Directed and randomized bench for core_pll_reset_seq, checked every cycle
// against a phase/elapsed-time reference model plus directed timing checks.
module tb_core_pll_reset_seq;

  localparam int P = 4;
  localparam int L = 8;
  localparam int T = 32;
  localparam int R = 2;

  localparam int PH_RST   = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_STAB  = 2;
  localparam int PH_RUN   = 3;
  localparam int PH_FAULT = 4;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_cnt;

  int n_tests;
  int n_fail;

  // Reference model: phase, cycles elapsed in phase, consecutive-lock run,
  // and the lock samples still in flight through the synchronizer.
  int   m_phase;
  int   m_el;
  int   m_run;
  int   m_retry;
  int   m_loss;
  logic m_s1;
  logic m_s2;

  core_pll_reset_seq #(
    .PLL_RST_CYCLES(P),
    .LOCK_STABLE_CYCLES(L),
    .LOCK_TIMEOUT_CYCLES(T),
    .MAX_RETRIES(R)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .fault(fault),
    .retry_count(retry_count),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_RST;
    m_el    = 0;
    m_run   = 0;
    m_retry = 0;
    m_loss  = 0;
    m_s1    = 1'b0;
    m_s2    = 1'b0;
  endtask

  task automatic model_step();
    logic ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_locked;
    case (m_phase)
      PH_RST: begin
        m_el++;
        if (m_el == P) begin
          m_phase = PH_WAIT;
          m_el    = 0;
        end
      end
      PH_WAIT: begin
        if (ls) begin
          m_phase = PH_STAB;
          m_run   = 0;
        end else begin
          m_el++;
          if (m_el == T) begin
            m_el = 0;
            if (m_retry == R) begin
              m_phase = PH_FAULT;
            end else begin
              m_retry++;
              m_phase = PH_RST;
            end
          end
        end
      end
      PH_STAB: begin
        if (!ls) begin
          m_phase = PH_WAIT;
          m_el    = 0;
        end else begin
          m_run++;
          if (m_run == L) begin
            m_phase = PH_RUN;
            m_retry = 0;
          end
        end
      end
      PH_RUN: begin
        if (!ls) begin
          m_loss  = (m_loss < 255) ? m_loss + 1 : 255;
          m_retry = 0;
          m_phase = PH_RST;
          m_el    = 0;
        end else if (relock_req) begin
          m_retry = 0;
          m_phase = PH_RST;
          m_el    = 0;
        end
      end
      default: begin
        if (relock_req) begin
          m_retry = 0;
          m_phase = PH_RST;
          m_el    = 0;
        end
      end
    endcase
  endtask

  task automatic check_model();
    chk("pll_rst",       32'(pll_rst),       32'(m_phase == PH_RST || m_phase == PH_FAULT));
    chk("sys_rst_n",     32'(sys_rst_n),     32'(m_phase == PH_RUN));
    chk("ready",         32'(ready),         32'(m_phase == PH_RUN));
    chk("fault",         32'(fault),         32'(m_phase == PH_FAULT));
    chk("retry_count",   32'(retry_count),   32'(m_retry));
    chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
  endtask

  task automatic tick();
    @(posedge refclk);
    if (rst_n) model_step();
    #1;
    check_model();
  endtask

  task automatic count_pll_rst_until(input logic v, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (pll_rst !== v && n < 200);
  endtask

  task automatic count_sys_until(input logic v, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sys_rst_n !== v && n < 200);
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int seg;
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_pll_rst", 32'(pll_rst), 32'd1);
    chk("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
    check_model();
    repeat (3) tick();
    rst_n = 1'b1;

    // Nominal bring-up.
    count_pll_rst_until(1'b0, n);
    chk("nom_pulse_len", 32'(n), 32'd4);
    repeat (10) tick();
    pll_locked = 1'b1;
    tick();
    count_sys_until(1'b1, n);
    chk("nom_release_latency", 32'(n), 32'd10);
    chk("nom_ready", 32'(ready), 32'd1);
    chk("nom_retry", 32'(retry_count), 32'd0);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    count_sys_until(1'b0, n);
    chk("loss_latency", 32'(n), 32'd3);
    chk("loss_pll_rst", 32'(pll_rst), 32'd1);
    chk("loss_cnt1", 32'(lock_loss_cnt), 32'd1);

    // Glitchy lock: 5 high, 1 low, then high.
    count_pll_rst_until(1'b0, n);
    chk("loss_pulse_len", 32'(n), 32'd4);
    pll_locked = 1'b1;
    tick();
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    count_sys_until(1'b1, n);
    chk("glitch_release_edge", 32'(n + 5), 32'd16);
    chk("glitch_retry", 32'(retry_count), 32'd0);

    // Never lock: three attempts then FAULT.
    pll_locked = 1'b0;
    hard_reset();
    for (int a = 0; a < 3; a++) begin
      count_pll_rst_until(1'b0, n);
      chk("nolock_pulse_len", 32'(n), 32'd4);
      count_pll_rst_until(1'b1, n);
      chk("nolock_window_len", 32'(n), 32'd32);
      if (a < 2) begin
        chk("nolock_retry", 32'(retry_count), 32'(a + 1));
        chk("nolock_no_fault", 32'(fault), 32'd0);
      end else begin
        chk("nolock_fault", 32'(fault), 32'd1);
        chk("nolock_retry_max", 32'(retry_count), 32'd2);
      end
    end
    repeat (5) tick();
    chk("fault_sticky", 32'(fault), 32'd1);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("fault_exit_retry", 32'(retry_count), 32'd0);
    chk("fault_exit_fault", 32'(fault), 32'd0);
    chk("fault_exit_pll_rst", 32'(pll_rst), 32'd1);
    count_pll_rst_until(1'b0, n);
    chk("relock_pulse_len", 32'(n), 32'd4);

    // relock_req in WAIT_LOCK is ignored.
    repeat (5) tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    count_pll_rst_until(1'b1, n);
    chk("wait_relock_window", 32'(n + 6), 32'd32);
    chk("wait_relock_retry", 32'(retry_count), 32'd1);

    // Asynchronous reset mid-STABILIZE.
    count_pll_rst_until(1'b0, n);
    chk("stab_pulse_len", 32'(n), 32'd4);
    pll_locked = 1'b1;
    tick();
    repeat (7) tick();
    chk("stab_not_released", 32'(sys_rst_n), 32'd0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_pll_rst", 32'(pll_rst), 32'd1);
    chk("async_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("async_retry", 32'(retry_count), 32'd0);
    check_model();
    tick();
    tick();
    rst_n = 1'b1;
    count_pll_rst_until(1'b0, n);
    chk("post_reset_pulse_len", 32'(n), 32'd4);
    count_sys_until(1'b1, n);
    chk("post_reset_release", 32'(n), 32'd9);

    // relock_req together with lock loss in RUN.
    pll_locked = 1'b0;
    tick();
    tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("simul_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("simul_pll_rst", 32'(pll_rst), 32'd1);
    chk("simul_loss", 32'(lock_loss_cnt), 32'd1);
    chk("simul_retry", 32'(retry_count), 32'd0);
    count_pll_rst_until(1'b0, n);
    chk("simul_pulse_len", 32'(n), 32'd4);

    // Randomized lock behaviour and relock requests.
    seg = 0;
    for (int c = 0; c < 2500; c++) begin
      if (seg == 0) begin
        pll_locked = ~pll_locked;
        seg = pll_locked ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 45));
      end
      seg--;
      relock_req = ($urandom_range(0, 19) == 0);
      tick();
    end
    relock_req = 1'b0;

    // Repeated lock loss saturates the counter.
    pll_locked = 1'b0;
    hard_reset();
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b1;
      count_sys_until(1'b1, n);
      pll_locked = 1'b0;
      count_sys_until(1'b0, n);
    end
    chk("loss_saturated", 32'(lock_loss_cnt), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_pll_reset_seq.md
CORE_PLL_RESET_SEQ -- requirements
Module: core_pll_reset_seq

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 10: refclk cycles pll_rst is held high per PLL reset pulse (range 1..255).
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release (range 1..65535).
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 100000: cycles allowed in WAIT_LOCK before an attempt fails (range 2..2^20).
REQ-004 Parameter MAX_RETRIES, default 3: failed attempts tolerated before FAULT (range 0..15).
REQ-005 refclk  in  1  sole clock, the PLL reference clock domain.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low; deassertion is synchronized to refclk at the integrating level, and this block adds no reset synchronizer.
REQ-007 pll_locked  in  1  PLL locked indication, asynchronous to refclk.
REQ-008 relock_req  in  1  single-cycle request to restart the sequence.
REQ-009 pll_rst  out  1  active-high reset to the PLL.
REQ-010 sys_rst_n  out  1  active-low reset for logic clocked by the PLL output.
REQ-011 ready  out  1  high only in RUN.
REQ-012 fault  out  1  high only in FAULT.
REQ-013 retry_count  out  4  failed lock attempts since the last RUN entry or relock.
REQ-014 lock_loss_cnt  out  8  saturating count of lock losses seen in RUN.

Function
REQ-015 pll_locked passes through a 2-flop synchronizer (lock_s); only lock_s is used.
REQ-016 FSM states: RESET_PLL, WAIT_LOCK, STABILIZE, RUN, FAULT.
REQ-017 All outputs are registered Moore decodes that update on the same edge as the state transition.
REQ-018 Output decode per state:
- RESET_PLL: pll_rst=1, sys_rst_n=0.
- WAIT_LOCK and STABILIZE: pll_rst=0, sys_rst_n=0.
- RUN: pll_rst=0, sys_rst_n=1, ready=1.
- FAULT: pll_rst=1, sys_rst_n=0, fault=1.
REQ-019 RESET_PLL: one shared cycle counter runs; after exactly PLL_RST_CYCLES cycles the FSM goes to WAIT_LOCK with the counter cleared.
REQ-020 WAIT_LOCK, lock_s=1: go to STABILIZE, counter cleared.
REQ-021 WAIT_LOCK timeout: if the counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0, the attempt has failed.
- If retry_count==MAX_RETRIES, go to FAULT.
- Otherwise increment retry_count and go to RESET_PLL.
REQ-022 STABILIZE: the counter increments each cycle lock_s=1; after LOCK_STABLE_CYCLES consecutive high cycles, go to RUN and clear retry_count.
REQ-023 STABILIZE, lock_s=0: return to WAIT_LOCK with the counter cleared (timeout window restarts); retry_count unchanged.
REQ-024 RUN, lock_s=0: go to RESET_PLL and increment lock_loss_cnt, saturating at 255; sys_rst_n falls on that same edge.
REQ-025 relock_req=1 in RUN or FAULT: go to RESET_PLL and clear retry_count.
REQ-026 relock_req is ignored in RESET_PLL, WAIT_LOCK and STABILIZE.
REQ-027 Simultaneous events in RUN (relock_req=1 and lock_s=0 on the same cycle): take the lock-loss path (increment lock_loss_cnt); retry_count is cleared.
REQ-028 FAULT is exited only by relock_req or rst_n.
REQ-029 Latency: if pll_locked rises before edge N and stays high, then lock_s=1 after edge N+1, STABILIZE is entered at N+2, and RUN (sys_rst_n=1) is entered at N+2+LOCK_STABLE_CYCLES.
REQ-030 The counter is wide enough for max(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES, PLL_RST_CYCLES) and never wraps within any state.

Reset
REQ-031 rst_n low asynchronously forces the following, regardless of state or counter:
- state=RESET_PLL, counter=0, synchronizer=0;
- pll_rst=1, sys_rst_n=0, ready=0, fault=0;
- retry_count=0, lock_loss_cnt=0.
REQ-032 After rst_n rises, the first PLL reset pulse lasts PLL_RST_CYCLES full cycles.

Verification
Bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
REQ-033 Nominal: release rst_n, raise pll_locked 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst_n=1 and ready=1 exactly 10 edges after lock sampled; retry_count=0.
REQ-034 Never lock -> three 4-cycle pll_rst pulses with 32-cycle WAIT_LOCK windows; retry_count steps 1,2; then fault=1, pll_rst=1, retry_count=2; relock_req -> retry_count=0, new pulse.
REQ-035 Glitchy lock: pll_locked high 5 cycles, low 1, then high -> no release at the first 8-cycle mark; sys_rst_n=1 only after 8 uninterrupted lock_s cycles; retry_count=0.
REQ-036 Lock loss in RUN: drop pll_locked -> sys_rst_n=0 and pll_rst=1 within 3 edges; lock_loss_cnt=1; repeat 300 times -> lock_loss_cnt=255.
REQ-037 Reset mid-STABILIZE: assert rst_n low at counter=5 -> all outputs at reset values immediately, without waiting for a refclk edge; on release the full sequence restarts with a 4-cycle pll_rst.
REQ-038 relock_req pulsed in WAIT_LOCK -> no effect; pulsed in RUN together with pll_locked low -> single RESET_PLL entry, lock_loss_cnt+1.
